// File: rtl/bounce_scan_ctrl.sv
// bounce_scan_ctrl
//   Steps a position counter between POS_MIN and POS_MAX. Each position
//   takes two phase steps. In bounce mode the sweep reverses at each end.
//   In wrap mode it jumps back to the start of the same direction. A
//   prescaler sets the step rate. Hold and enable freeze the sequence.
//
// Ports
//   ck        : clock, rising edge
//   reset     : asynchronous, active-high reset
//   en        : run enable (0 also clears the prescaler)
//   hold      : freeze sequence and prescaler
//   mode      : 0 = bounce, 1 = wrap (sampled only at an end decision)
//   div       : step period minus one (0 = step every cycle)
//   phase     : phase code UP_A=1, UP_B=5, DN_A=4, DN_B=2
//               (this is the FSM state register itself)
//   pos       : current position
//   dir       : 0 = ascending, 1 = descending
//   end_pulse : one-cycle pulse after a turnaround or wrap edge
//
// Handshake: there is none. en/hold/mode/div are level controls sampled on
// every rising edge of ck. All outputs are registered.
module bounce_scan_ctrl #(
  parameter int POS_W   = 3,
  parameter int POS_MIN = 1,
  parameter int POS_MAX = 6,
  parameter int DIV_W   = 8
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             en,
  input  logic             hold,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       phase,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             end_pulse
);

  // The state encodings are the phase codes. The phase output is then the
  // state register with no decode in between.
  typedef enum logic [2:0] {
    UP_A = 3'd1,
    UP_B = 3'd5,
    DN_A = 3'd4,
    DN_B = 3'd2
  } state_t;

  localparam logic [POS_W-1:0] PMIN = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               end_q, end_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               tick;

  // The >= compare lets a div lowered mid-count fire on the next cycle.
  // An equality compare would instead run past the new value and overrun.
  assign tick = en & ~hold & (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q;
    if (!en)       cnt_d = '0;          // en=0 dominates hold
    else if (hold) cnt_d = cnt_q;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    end_d   = 1'b0;
    case (state_q)
      UP_A: if (tick) state_d = UP_B;
      UP_B: if (tick) begin
        if (pos_q != PMAX) begin
          pos_d   = pos_q + 1'b1;
          state_d = UP_A;
        end else if (!mode) begin
          state_d = DN_A;
          dir_d   = 1'b1;
          end_d   = 1'b1;
        end else begin
          pos_d   = PMIN;
          state_d = UP_A;
          end_d   = 1'b1;
        end
      end
      DN_A: if (tick) state_d = DN_B;
      DN_B: if (tick) begin
        if (pos_q != PMIN) begin
          pos_d   = pos_q - 1'b1;
          state_d = DN_A;
        end else if (!mode) begin
          state_d = UP_A;
          dir_d   = 1'b0;
          end_d   = 1'b1;
        end else begin
          pos_d   = PMAX;
          state_d = DN_A;
          end_d   = 1'b1;
        end
      end
      default: begin
        // An unused encoding returns to the reset point without waiting for tick.
        state_d = UP_A;
        pos_d   = PMIN;
        dir_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q <= UP_A;
      pos_q   <= PMIN;
      dir_q   <= 1'b0;
      end_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase     = state_q;
  assign pos       = pos_q;
  assign dir       = dir_q;
  assign end_pulse = end_q;

endmodule

// File: tb/tb_bounce_scan_ctrl.sv
module tb_bounce_scan_ctrl;

  // ---------------- clock / reset ----------------
  logic ck = 1'b0;
  logic reset = 1'b1;
  always #5 ck = ~ck;

  logic       en = 1'b0, hold = 1'b0, mode = 1'b0;
  logic [7:0] div = 8'd0;
  logic [2:0] phase;
  logic [2:0] pos;
  logic       dir, end_pulse;

  logic       en2 = 1'b0;
  logic [2:0] phase2;
  logic [3:0] pos2;
  logic       dir2, end2;

  bounce_scan_ctrl u_dut (
    .ck(ck), .reset(reset), .en(en), .hold(hold), .mode(mode), .div(div),
    .phase(phase), .pos(pos), .dir(dir), .end_pulse(end_pulse)
  );

  bounce_scan_ctrl #(.POS_W(4), .POS_MIN(3), .POS_MAX(12), .DIV_W(8)) u_dut2 (
    .ck(ck), .reset(reset), .en(en2), .hold(1'b0), .mode(1'b0), .div(8'd0),
    .phase(phase2), .pos(pos2), .dir(dir2), .end_pulse(end2)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       en;
    logic       hold;
    logic       mode;
    logic [7:0] div;
    logic [2:0] ph;
    logic [2:0] pos;
    logic       dir;
    logic       endp;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic e, input logic h, input logic m, input logic [7:0] d,
                   input logic [2:0] ph, input logic [2:0] p, input logic dr, input logic ep);
    vec_t x;
    x.en = e; x.hold = h; x.mode = m; x.div = d;
    x.ph = ph; x.pos = p; x.dir = dr; x.endp = ep;
    tbl.push_back(x);
  endtask

  // ---------------- driver tasks ----------------
  task automatic edges(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge ck); #1;
    reset = 1'b1;
    edges(2);
    reset = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ph/pos/dir/end=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               name, act[7:5], act[4:2], act[1], act[0],
               exp[7:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [7:0] pk(input logic [2:0] ph, input logic [2:0] p,
                                    input logic dr, input logic ep);
    return {ph, p, dr, ep};
  endfunction

  // scoreboard for the wide-parameter instance: {phase, pos, dir, end}
  logic [8:0] exp_q[$];

  initial begin
    logic [8:0] e;
    logic [8:0] seq[40];
    logic [8:0] got;

    // ---- reset state ----
    #12;
    chk("reset_state", {phase, pos, dir, end_pulse}, pk(3'd1, 3'd1, 1'b0, 1'b0));
    checks++;
    if ({phase2, pos2, dir2, end2} !== {3'd1, 4'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state_w: got %0d/%0d want 1/3", phase2, pos2);
    end

    // ---- test 1: full bounce, div=0 ----
    v(1,0,0,0, 5,1,0,0);
    v(1,0,0,0, 1,2,0,0); v(1,0,0,0, 5,2,0,0);
    v(1,0,0,0, 1,3,0,0); v(1,0,0,0, 5,3,0,0);
    v(1,0,0,0, 1,4,0,0); v(1,0,0,0, 5,4,0,0);
    v(1,0,0,0, 1,5,0,0); v(1,0,0,0, 5,5,0,0);
    v(1,0,0,0, 1,6,0,0); v(1,0,0,0, 5,6,0,0);
    v(1,0,0,0, 4,6,1,1); v(1,0,0,0, 2,6,1,0);
    v(1,0,0,0, 4,5,1,0); v(1,0,0,0, 2,5,1,0);
    v(1,0,0,0, 4,4,1,0); v(1,0,0,0, 2,4,1,0);
    v(1,0,0,0, 4,3,1,0); v(1,0,0,0, 2,3,1,0);
    v(1,0,0,0, 4,2,1,0); v(1,0,0,0, 2,2,1,0);
    v(1,0,0,0, 4,1,1,0); v(1,0,0,0, 2,1,1,0);
    v(1,0,0,0, 1,1,0,1); v(1,0,0,0, 5,1,0,0);
    // ---- test 3: hold at (5,3) ----
    v(1,0,0,0, 1,2,0,0); v(1,0,0,0, 5,2,0,0);
    v(1,0,0,0, 1,3,0,0); v(1,0,0,0, 5,3,0,0);
    for (int i = 0; i < 5; i++) v(1,1,0,0, 5,3,0,0);
    v(1,0,0,0, 1,4,0,0);
    // ---- en=0 freeze, then div=2: first step on the third edge ----
    for (int i = 0; i < 3; i++) v(0,0,0,0, 1,4,0,0);
    v(1,0,0,2, 1,4,0,0); v(1,0,0,2, 1,4,0,0); v(1,0,0,2, 5,4,0,0);
    v(1,0,0,2, 5,4,0,0); v(1,0,0,2, 5,4,0,0); v(1,0,0,2, 1,5,0,0);
    // ---- test 2: div=3 four cycles per value, then div 3->1 at cnt=3 ----
    for (int i = 0; i < 3; i++) v(1,0,0,3, 1,5,0,0);
    v(1,0,0,3, 5,5,0,0);
    for (int i = 0; i < 3; i++) v(1,0,0,3, 5,5,0,0);
    v(1,0,0,3, 1,6,0,0);
    for (int i = 0; i < 3; i++) v(1,0,0,3, 1,6,0,0);
    v(1,0,0,1, 5,6,0,0); v(1,0,0,1, 5,6,0,0);
    v(1,0,0,1, 4,6,1,1); v(1,0,0,1, 4,6,1,0);
    v(1,0,0,1, 2,6,1,0);
    // ---- test 4b: wrap while descending ----
    v(1,0,1,0, 4,5,1,0); v(1,0,1,0, 2,5,1,0);
    v(1,0,1,0, 4,4,1,0); v(1,0,1,0, 2,4,1,0);
    v(1,0,1,0, 4,3,1,0); v(1,0,1,0, 2,3,1,0);
    v(1,0,1,0, 4,2,1,0); v(1,0,1,0, 2,2,1,0);
    v(1,0,1,0, 4,1,1,0); v(1,0,1,0, 2,1,1,0);
    v(1,0,1,0, 4,6,1,1); v(1,0,1,0, 2,6,1,0);

    @(posedge ck); #1;
    reset = 1'b0;
    foreach (tbl[i]) begin
      en = tbl[i].en; hold = tbl[i].hold; mode = tbl[i].mode; div = tbl[i].div;
      edges(1);
      chk($sformatf("vec%0d", i), {phase, pos, dir, end_pulse},
          pk(tbl[i].ph, tbl[i].pos, tbl[i].dir, tbl[i].endp));
    end

    // ---- test 4a: wrap mode from reset ----
    en = 1'b0; hold = 1'b0; mode = 1'b1; div = 8'd0;
    do_reset();
    en = 1'b1;
    edges(11);
    chk("wrap_pre", {phase, pos, dir, end_pulse}, pk(3'd5, 3'd6, 1'b0, 1'b0));
    edges(1);
    chk("wrap_up", {phase, pos, dir, end_pulse}, pk(3'd1, 3'd1, 1'b0, 1'b1));
    edges(1);
    chk("wrap_post", {phase, pos, dir, end_pulse}, pk(3'd5, 3'd1, 1'b0, 1'b0));

    // ---- test 5: asynchronous reset between edges at (2,4) ----
    en = 1'b0; mode = 1'b0;
    do_reset();
    en = 1'b1;
    edges(17);
    chk("pre_async", {phase, pos, dir, end_pulse}, pk(3'd2, 3'd4, 1'b1, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", {phase, pos, dir, end_pulse}, pk(3'd1, 3'd1, 1'b0, 1'b0));
    edges(2);
    reset = 1'b0;
    chk("after_rel", {phase, pos, dir, end_pulse}, pk(3'd1, 3'd1, 1'b0, 1'b0));
    edges(1);
    chk("restart", {phase, pos, dir, end_pulse}, pk(3'd5, 3'd1, 1'b0, 1'b0));

    // ---- test 6: POS 3..12, period 40 ----
    en = 1'b0;
    do_reset();
    for (int p = 3; p <= 12; p++) begin
      seq[(p-3)*2]     = {3'd1, 4'(p), 1'b0, 1'b0};
      seq[(p-3)*2 + 1] = {3'd5, 4'(p), 1'b0, 1'b0};
    end
    for (int p = 12; p >= 3; p--) begin
      seq[20 + (12-p)*2]     = {3'd4, 4'(p), 1'b1, 1'b0};
      seq[20 + (12-p)*2 + 1] = {3'd2, 4'(p), 1'b1, 1'b0};
    end
    seq[20][0] = 1'b1;  // pulse following the turnaround at 12
    seq[0][0]  = 1'b1;  // pulse following the turnaround at 3
    for (int k = 1; k <= 41; k++) exp_q.push_back(seq[k % 40]);
    en2 = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      edges(1);
      e = exp_q.pop_front();
      got = {phase2, pos2, dir2, end2};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wide_step%0d: got ph/pos/dir/end=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 k, got[8:6], got[5:2], got[1], got[0], e[8:6], e[5:2], e[1], e[0]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bounce_scan_ctrl.md
Name: bounce_scan_ctrl

Overview:
Parametrised successor to the two-phase bounce sequencer. It drives a position counter between POS_MIN and POS_MAX, with a two-step phase code per position. It adds a programmable step-rate prescaler, enable/hold control, a selectable bounce or wrap mode, a direction flag and a turnaround pulse. It feeds the display/actuator pattern logic that consumes phase and position codes.

Parameters:
POS_W, 3, width of pos output
POS_MIN, 1, lowest position; legal range 0 <= POS_MIN < POS_MAX
POS_MAX, 6, highest position; must be < 2**POS_W
DIV_W, 8, width of prescaler divide value and counter

Ports:
ck  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  run enable
hold  input  1  freeze sequence and prescaler
mode  input  1  0 = bounce, 1 = wrap
div  input  DIV_W  step period minus one (0 = step every cycle)
phase  output  3  phase code: UP_A=1, UP_B=5, DN_A=4, DN_B=2
pos  output  POS_W  current position
dir  output  1  0 = ascending, 1 = descending
end_pulse  output  1  one-cycle pulse on a turnaround or wrap

Behaviour:
- Reset (async, active-high): state=UP_A, phase=1, pos=POS_MIN, dir=0, end_pulse=0, prescaler cnt=0. All outputs are registered.
- Prescaler: tick = en & ~hold & (cnt >= div), combinational from registered cnt.
  - On tick: cnt <= 0.
  - Else if en & ~hold: cnt <= cnt+1.
  - If hold: cnt is held.
  - If en=0: cnt <= 0. en=0 dominates hold.
- The >= compare means a div reduced mid-count takes effect on the next cycle without overrun.
- State advances only on a clock edge where tick=1. Outputs change on that edge, so latency from tick to new phase/pos is 1 edge.
- FSM transitions on tick:
  - UP_A -> UP_B (phase 5), pos unchanged.
  - UP_B:
    - pos != POS_MAX: pos+1 -> UP_A (phase 1).
    - pos == POS_MAX, mode=0: -> DN_A (phase 4), dir=1, end_pulse=1, pos unchanged.
    - pos == POS_MAX, mode=1: pos=POS_MIN -> UP_A (phase 1), end_pulse=1.
  - DN_A -> DN_B (phase 2), pos unchanged.
  - DN_B:
    - pos != POS_MIN: pos-1 -> DN_A (phase 4).
    - pos == POS_MIN, mode=0: -> UP_A (phase 1), dir=0, end_pulse=1.
    - pos == POS_MIN, mode=1: pos=POS_MAX -> DN_A (phase 4), end_pulse=1.
- Bounce period with defaults: 24 ticks.
  - (1,1)(5,1)(1,2)(5,2)…(5,6) then (4,6)(2,6)(4,5)…(2,1), then back to (1,1).
- end_pulse is high for exactly the one cycle following the turnaround edge. It is 0 on every other cycle, including while held.
- dir always equals 1 in DN_A/DN_B and 0 in UP_A/UP_B.
- mode is sampled only at the boundary decision. Changing it mid-sweep causes no glitch.
- hold or en=0 freeze state, phase, pos and dir. Resuming continues from the frozen point. After en=0 the prescaler restarts the full period.
- Illegal state encoding recovers to UP_A, pos=POS_MIN, dir=0 on the next edge regardless of tick.
- Reset mid-operation returns all outputs to reset values immediately, without waiting for an edge.
- Position arithmetic is modulo 2**POS_W. Parameter legality guarantees no overflow.

Test Plan:
1. Default params, en=1, div=0, mode=0, release reset:
   - (phase,pos) follows the 24-step sequence above and repeats.
   - end_pulse is high in the cycles showing (4,6) and (1,1) after turnaround.
   - dir toggles at each turnaround.
2. div=3, en=1: each phase/pos value holds for exactly 4 cycles. Change div 3->1 when cnt=3: tick occurs on that cycle, then every 2 cycles.
3. Assert hold for 5 cycles at (5,3), div=0: outputs stay at (5,3), end_pulse=0. Release: next edge gives (1,4). Repeat the test with en=0: after re-enabling with div=2, the first step comes 3 cycles later.
4. mode=1 from reset: (5,6) is followed by (1,1) with end_pulse=1 and dir=0. With mode switched to 1 while descending: (2,1) is followed by (4,6) with dir=1.
5. Assert reset asynchronously between edges mid-sweep at (2,4):
   - phase=1, pos=1, dir=0, end_pulse=0 immediately.
   - After release, the sequence restarts from (1,1).
6. Params POS_W=4, POS_MIN=3, POS_MAX=12, div=0: pos sweeps 3..12..3, bounce period 40 ticks, end_pulse at pos 12 and pos 3.
